// File: rtl/step_cnt.sv
// Bounded up/down counter with small/large steps, saturate-or-wrap limits and
// press-and-hold auto-repeat (initial delay, then a faster repeat period).
module step_cnt #(
   parameter int W       = 8,
   parameter int STEP_S  = 1,
   parameter int STEP_L  = 10,
   parameter int WRAP    = 0,
   parameter int RDW     = 24,
   parameter int REP_DLY = 12000000,
   parameter int REP_PER = 2000000
) (
   input  logic         RSTX,
   input  logic         CLK,
   input  logic [W-1:0] UBND,
   input  logic [W-1:0] LBND,
   input  logic         CLR,
   input  logic         LOAD,
   input  logic [W-1:0] LDAT,
   input  logic         INC_S,
   input  logic         INC_L,
   input  logic         DEC_S,
   input  logic         DEC_L,
   output logic [W-1:0] CNT,
   output logic         AT_MAX,
   output logic         AT_MIN,
   output logic         STEP_P
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_REPEAT = 2'd2} state_t;
   typedef enum logic [2:0] {CMD_NONE = 3'd0, CMD_INC_S = 3'd1, CMD_INC_L = 3'd2,
                             CMD_DEC_S = 3'd3, CMD_DEC_L = 3'd4} cmd_t;

   localparam int             WP1     = W + 1;
   localparam logic [W:0]     STEP_SW = WP1'(STEP_S);
   localparam logic [W:0]     STEP_LW = WP1'(STEP_L);
   localparam logic [RDW-1:0] DLY_END = RDW'(REP_DLY - 1);
   localparam logic [RDW-1:0] PER_END = RDW'(REP_PER - 1);

   // Next count for one step; W+1-bit arithmetic so CNT+step and LBND+step never overflow.
   function automatic logic [W-1:0] f_step(input logic [W-1:0] cnt, input logic [W-1:0] ubnd,
                                           input logic [W-1:0] lbnd, input cmd_t cmd);
      logic [W:0] c, u, l, s, res;
      logic       inc;
      c = {1'b0, cnt};
      u = {1'b0, ubnd};
      l = {1'b0, lbnd};
      case (cmd)
         CMD_INC_S: begin s = STEP_SW; inc = 1'b1; end
         CMD_INC_L: begin s = STEP_LW; inc = 1'b1; end
         CMD_DEC_S: begin s = STEP_SW; inc = 1'b0; end
         CMD_DEC_L: begin s = STEP_LW; inc = 1'b0; end
         default:   begin s = {WP1{1'b0}}; inc = 1'b1; end
      endcase
      if (c > u) begin
         res = u;
      end else if (c < l) begin
         res = l;
      end else if (inc) begin
         if (c + s > u) res = (WRAP != 0) ? l : u;
         else           res = c + s;
      end else begin
         if (c < l + s) res = (WRAP != 0) ? u : l;
         else           res = c - s;
      end
      return res[W-1:0];
   endfunction

   function automatic logic [W-1:0] f_clamp(input logic [W-1:0] d, input logic [W-1:0] ubnd,
                                            input logic [W-1:0] lbnd);
      logic [W-1:0] res;
      if (d > ubnd)      res = ubnd;
      else if (d < lbnd) res = lbnd;
      else               res = d;
      return res;
   endfunction

   state_t         r_state;
   cmd_t           r_cmd;
   logic [RDW-1:0] r_timer;
   logic [W-1:0]   r_cnt;
   logic           r_step_p;

   cmd_t         w_cmd;
   logic         w_tmo;
   logic         w_fire;
   logic         w_bnd_ok;
   logic [W-1:0] w_stepped;

   // Command priority, repeat timeout and whether a step lands this cycle.
   always_comb begin
      w_cmd = CMD_NONE;
      if (INC_S)      w_cmd = CMD_INC_S;
      else if (INC_L) w_cmd = CMD_INC_L;
      else if (DEC_S) w_cmd = CMD_DEC_S;
      else if (DEC_L) w_cmd = CMD_DEC_L;
      else            w_cmd = CMD_NONE;

      case (r_state)
         ST_HOLD:   w_tmo = (r_timer == DLY_END);
         ST_REPEAT: w_tmo = (r_timer == PER_END);
         default:   w_tmo = 1'b0;
      endcase

      if (CLR || LOAD || (w_cmd == CMD_NONE)) begin
         w_fire = 1'b0;
      end else begin
         w_fire = (r_state == ST_IDLE) || (w_cmd != r_cmd) || w_tmo;
      end

      w_bnd_ok  = (LBND <= UBND);
      w_stepped = f_step(r_cnt, UBND, LBND, w_cmd);
   end

   // Repeat FSM, count register and step pulse.
   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         r_state  <= ST_IDLE;
         r_cmd    <= CMD_NONE;
         r_timer  <= {RDW{1'b0}};
         r_cnt    <= {W{1'b0}};
         r_step_p <= 1'b0;
      end else begin
         r_step_p <= w_fire;
         if (CLR) begin
            r_cnt   <= LBND;
            r_state <= ST_IDLE;
            r_cmd   <= CMD_NONE;
            r_timer <= {RDW{1'b0}};
         end else if (LOAD) begin
            if (w_bnd_ok) r_cnt <= f_clamp(LDAT, UBND, LBND);
            else          r_cnt <= r_cnt;
            r_state <= ST_IDLE;
            r_cmd   <= CMD_NONE;
            r_timer <= {RDW{1'b0}};
         end else begin
            if (w_fire && w_bnd_ok) r_cnt <= w_stepped;
            else                    r_cnt <= r_cnt;
            case (r_state)
               ST_IDLE: begin
                  r_timer <= {RDW{1'b0}};
                  r_cmd   <= w_cmd;
                  if (w_cmd != CMD_NONE) r_state <= ST_HOLD;
                  else                   r_state <= ST_IDLE;
               end
               ST_HOLD, ST_REPEAT: begin
                  r_cmd <= w_cmd;
                  if (w_cmd == CMD_NONE) begin
                     r_state <= ST_IDLE;
                     r_timer <= {RDW{1'b0}};
                  end else if (w_cmd != r_cmd) begin
                     r_state <= ST_HOLD;
                     r_timer <= {RDW{1'b0}};
                  end else if (w_tmo) begin
                     r_state <= ST_REPEAT;
                     r_timer <= {RDW{1'b0}};
                  end else begin
                     r_state <= r_state;
                     r_timer <= r_timer + RDW'(1);
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_cmd   <= CMD_NONE;
                  r_timer <= {RDW{1'b0}};
               end
            endcase
         end
      end
   end

   assign CNT    = r_cnt;
   assign STEP_P = r_step_p;
   assign AT_MAX = (r_cnt == UBND);
   assign AT_MIN = (r_cnt == LBND);

endmodule
